// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N:1 selector with valid/ready on every port.
// Contending sources are arbitrated round-robin (ARB_MODE=0) or by fixed
// priority with the lowest index winning (ARB_MODE=1). The winner is held in
// a one-entry output register that drains and refills in the same cycle.
module rr_mux_reg #(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int ARB_MODE = 0,
  localparam int SELW    = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel
);

  logic [SELW-1:0]  last;     // channel granted most recently (round-robin)
  logic [SELW-1:0]  win;      // combinational winner
  logic             any_req;  // at least one channel is requesting
  logic             load;     // output register may take a new word
  logic [WIDTH-1:0] lane_data [N];

  // Unpack the flat data bus into one word per lane.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load = !out_valid || out_ready;

  // Grant: scan from last+1 with an explicit wrap so non-power-of-two N
  // goes N-1 -> 0, or take the lowest requesting index in fixed mode.
  always_comb begin
    logic [SELW:0] cand;
    win     = '0;
    any_req = 1'b0;
    cand    = '0;
    if (ARB_MODE == 0) begin
      for (int j = 0; j < N; j++) begin
        cand = {1'b0, last} + (SELW+1)'(j + 1);
        if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
        if (!any_req && in_valid[cand[SELW-1:0]]) begin
          any_req = 1'b1;
          win     = cand[SELW-1:0];
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!any_req && in_valid[i]) begin
          any_req = 1'b1;
          win     = SELW'(i);
        end
      end
    end
  end

  // One-hot accept to the winner; nothing is accepted while reset is applied.
  always_comb begin
    in_ready = '0;
    if (!rst && load && any_req) in_ready[win] = 1'b1;
  end

  // Output register and round-robin pointer; a drain with no refill clears
  // only the valid flag so data/sel keep the last word for observability.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SELW'(N - 1);
    end else if (load && any_req) begin
      out_valid <= 1'b1;
      out_data  <= lane_data[win];
      out_sel   <= win;
      if (ARB_MODE == 0) last <= win;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
